// File: rtl/apb_master_if.sv
// apb_master_if: command-side and APB-side signals of the apb_master, grouped with master/slave views
interface apb_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();
   logic [1:0]            cmd;
   logic [ADDR_WIDTH-1:0] saddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  pready;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  psel0;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] rdata;
   modport master (
      input  cmd, saddr, wdata, pready, prdata,
      output psel0, penable, pwrite, paddr, pwdata, rdata
   );
   modport slave (
      output cmd, saddr, wdata, pready, prdata,
      input  psel0, penable, pwrite, paddr, pwdata, rdata
   );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-slave APB master turning cmd/saddr/wdata into APB transfers; APB_MASTER_B2B_EN enables back-to-back transfers
module apb_master (
   input logic          pclk,
   input logic          presetn,
   apb_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t state;
   logic   start;
   logic   is_wr;
   assign is_wr = bus.cmd == 2'b10;
   assign start = bus.cmd == 2'b01 || is_wr;
   // APB phase sequencing with registered bus outputs; a new command latches address, direction and write data
   always_ff @(posedge pclk or negedge presetn)
      if (!presetn) begin
         state       <= IDLE;
         bus.psel0   <= 1'b0;
         bus.penable <= 1'b0;
         bus.pwrite  <= 1'b0;
         bus.paddr   <= '0;
         bus.pwdata  <= '0;
         bus.rdata   <= '0;
      end else begin
         case (state)
            IDLE:
               if (start) begin
                  state      <= SETUP;
                  bus.psel0  <= 1'b1;
                  bus.paddr  <= bus.saddr;
                  bus.pwrite <= is_wr;
                  if (is_wr) bus.pwdata <= bus.wdata;
               end
            SETUP: begin
               state       <= ACCESS;
               bus.penable <= 1'b1;
            end
            ACCESS:
               if (bus.pready) begin
                  bus.penable <= 1'b0;
                  if (!bus.pwrite) bus.rdata <= bus.prdata;
`ifdef APB_MASTER_B2B_EN
                  if (start) begin
                     state      <= SETUP;
                     bus.paddr  <= bus.saddr;
                     bus.pwrite <= is_wr;
                     if (is_wr) bus.pwdata <= bus.wdata;
                  end else begin
                     state     <= IDLE;
                     bus.psel0 <= 1'b0;
                  end
`else
                  state     <= IDLE;
                  bus.psel0 <= 1'b0;
`endif
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed checks of reset, write, wait states, read, back-to-back and async reset
module tb_apb_master;
   logic pclk = 1'b0;
   logic presetn = 1'b0;
   int   errs = 0;
   int   total = 0;
   apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   apb_master dut (.pclk(pclk), .presetn(presetn), .bus(bus.master));
   always #5 pclk = ~pclk;
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic chk_bus(input string tag, input logic s, input logic e);
      chk({tag, "_psel0"}, {31'd0, bus.psel0}, {31'd0, s});
      chk({tag, "_penable"}, {31'd0, bus.penable}, {31'd0, e});
   endtask
   initial begin
      bus.cmd = 2'b10; bus.saddr = 32'h0000_1111; bus.wdata = 32'h0000_EEEE;
      bus.pready = 1'b1; bus.prdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_bus("rst_hold", 1'b0, 1'b0);
      end
      chk("rst_pwrite", {31'd0, bus.pwrite}, 32'd0);
      chk("rst_paddr", bus.paddr, 32'h0);
      chk("rst_pwdata", bus.pwdata, 32'h0);
      chk("rst_rdata", bus.rdata, 32'h0);
      bus.cmd = 2'b00; presetn = 1'b1;
      tick();
      chk_bus("idle_after_rst", 1'b0, 1'b0);
      chk("idle_paddr", bus.paddr, 32'h0);
      bus.cmd = 2'b11;
      tick();
      chk_bus("cmd11_nop", 1'b0, 1'b0);
      bus.cmd = 2'b10; bus.saddr = 32'h0000_1111; bus.wdata = 32'h0000_EEEE;
      tick();
      bus.cmd = 2'b00;
      chk_bus("wr_setup", 1'b1, 1'b0);
      chk("wr_pwrite", {31'd0, bus.pwrite}, 32'd1);
      chk("wr_paddr", bus.paddr, 32'h0000_1111);
      chk("wr_pwdata", bus.pwdata, 32'h0000_EEEE);
      tick();
      chk_bus("wr_access", 1'b1, 1'b1);
      tick();
      chk_bus("wr_idle", 1'b0, 1'b0);
      chk("wr_paddr_kept", bus.paddr, 32'h0000_1111);
      bus.pready = 1'b0; bus.cmd = 2'b10; bus.saddr = 32'h0000_2222; bus.wdata = 32'h0000_1234;
      tick();
      bus.cmd = 2'b00; bus.wdata = 32'h0000_DDDD; bus.saddr = 32'h0000_9999;
      chk_bus("ws_setup", 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk_bus("ws_wait", 1'b1, 1'b1);
         chk("ws_pwdata", bus.pwdata, 32'h0000_1234);
         chk("ws_paddr", bus.paddr, 32'h0000_2222);
         tick();
      end
      chk_bus("ws_last", 1'b1, 1'b1);
      bus.pready = 1'b1;
      tick();
      chk_bus("ws_idle", 1'b0, 1'b0);
      bus.cmd = 2'b01; bus.saddr = 32'h0000_1111; bus.prdata = 32'hFFFF_0000;
      tick();
      bus.cmd = 2'b00;
      chk_bus("rd_setup", 1'b1, 1'b0);
      chk("rd_pwrite", {31'd0, bus.pwrite}, 32'd0);
      chk("rd_paddr", bus.paddr, 32'h0000_1111);
      chk("rd_pwdata_kept", bus.pwdata, 32'h0000_1234);
      tick();
      chk_bus("rd_access", 1'b1, 1'b1);
      chk("rd_rdata_before", bus.rdata, 32'h0);
      tick();
      chk_bus("rd_idle", 1'b0, 1'b0);
      chk("rd_rdata", bus.rdata, 32'hFFFF_0000);
      bus.cmd = 2'b10; bus.saddr = 32'h0000_0003; bus.wdata = 32'h0000_AAAA; bus.prdata = 32'h5555_5555;
      tick();
      bus.cmd = 2'b00;
      tick();
      tick();
      chk_bus("wr2_idle", 1'b0, 1'b0);
      chk("wr2_rdata_kept", bus.rdata, 32'hFFFF_0000);
      chk("wr2_pwdata", bus.pwdata, 32'h0000_AAAA);
      bus.cmd = 2'b10; bus.saddr = 32'h0000_0010; bus.wdata = 32'h0000_EEEE;
      tick();
      bus.saddr = 32'h0000_0014; bus.wdata = 32'h0000_DDDD;
      chk_bus("b2b_setup1", 1'b1, 1'b0);
      tick();
      chk_bus("b2b_access1", 1'b1, 1'b1);
      chk("b2b_pwdata1", bus.pwdata, 32'h0000_EEEE);
      tick();
`ifdef APB_MASTER_B2B_EN
      chk_bus("b2b_setup2", 1'b1, 1'b0);
      chk("b2b_pwdata2", bus.pwdata, 32'h0000_DDDD);
      chk("b2b_paddr2", bus.paddr, 32'h0000_0014);
      bus.cmd = 2'b00;
      tick();
      chk_bus("b2b_access2", 1'b1, 1'b1);
      tick();
      chk_bus("b2b_idle", 1'b0, 1'b0);
`else
      chk_bus("nob2b_gap", 1'b0, 1'b0);
      tick();
      bus.cmd = 2'b00;
      chk_bus("nob2b_setup2", 1'b1, 1'b0);
      chk("nob2b_pwdata2", bus.pwdata, 32'h0000_DDDD);
      chk("nob2b_paddr2", bus.paddr, 32'h0000_0014);
      tick();
      chk_bus("nob2b_access2", 1'b1, 1'b1);
      tick();
      chk_bus("nob2b_idle", 1'b0, 1'b0);
`endif
      bus.cmd = 2'b10; bus.saddr = 32'h0000_0020; bus.wdata = 32'h0000_0777; bus.pready = 1'b0;
      tick();
      bus.cmd = 2'b00;
      tick();
      chk_bus("arst_access", 1'b1, 1'b1);
      #2 presetn = 1'b0;
      #1;
      chk_bus("arst_async", 1'b0, 1'b0);
      chk("arst_paddr", bus.paddr, 32'h0);
      chk("arst_rdata", bus.rdata, 32'h0);
      bus.pready = 1'b1;
      tick();
      presetn = 1'b1;
      tick();
      chk_bus("arst_idle", 1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errs, total);
      $finish;
   end
endmodule
